vending_ctrl: RTL and testbench
===============================

VENDING_CTRL -- requirements
Module: vending_ctrl

Interface
REQ-001 Parameters, one per line: name, default, meaning:
  N_ITEMS  5  number of selectable items, legal range 2..8
  CREDIT_W  7  width of credit and price values
  MAX_CREDIT  99  credit saturation ceiling
  PRICES  {8,10,6,5,7}  packed N_ITEMS*CREDIT_W vector; item i occupies bits [i*CREDIT_W +: CREDIT_W]
  DENY_CYCLES  4  length of the deny indication in clk cycles
REQ-002 Ports, one per line: name, direction, width, meaning:
  clk  in  1  single clock
  rst  in  1  reset, asynchronous, active-low
  L_button  in  1  move selection left
  R_button  in  1  move selection right
  C_button  in  1  purchase the selected item
  switch  in  4  coin inputs; bits 0..3 = 1, 5, 10, 20
  sel  out  3  selected item index
  price  out  CREDIT_W  price of the selected item
  credit  out  CREDIT_W  current credit
  afford  out  N_ITEMS  bit i = (credit >= price of item i)
  vend  out  1  one-cycle pulse on a successful purchase
  vend_item  out  3  item index that was vended; valid while vend=1
  deny  out  1  high while the deny indication is active
REQ-003 One clock and one reset: clk is the only clock; rst is asynchronous and active-low.

Function
REQ-004 Every button and switch bit shall pass a 2-flop synchroniser and then a rising-edge detector; each 0->1 transition yields exactly one event, and holding an input high yields no further events.
REQ-005 Latency: outputs shall reflect an event on the 3rd rising clk edge after the first edge that samples the input high.
REQ-006 FSM states and transitions:
  IDLE: credit = 0. Coin event -> CREDIT.
  CREDIT: browse and buy. Successful C -> VEND; insufficient C -> DENY.
  VEND: one cycle, vend = 1. Next state CREDIT if remaining credit > 0, otherwise IDLE.
  DENY: lasts DENY_CYCLES cycles, then CREDIT.
REQ-007 Coin add: all switch rising edges in the same cycle shall be summed; credit = min(credit + sum, MAX_CREDIT); any excess is discarded. Coins shall be accepted in every state.
REQ-008 Navigation: R moves sel from i to (i+1) mod N_ITEMS; L moves sel from i to (i-1) mod N_ITEMS, wrapping 0 to N_ITEMS-1. L and R in the same cycle shall be ignored. Navigation shall be accepted in IDLE and CREDIT, and ignored in VEND and DENY.
REQ-009 Purchase: C in CREDIT with credit >= price shall set credit -= price and assert vend for one cycle with vend_item = sel. C in IDLE shall enter DENY.
REQ-010 C arriving in the same cycle as a coin shall be evaluated against the pre-coin credit; the coin is then added after any deduction.
REQ-011 C during VEND or DENY shall be ignored, and the DENY counter shall not restart.
REQ-012 price, afford and deny shall be combinational from registered state; credit and sel shall be registered.
REQ-013 Arithmetic shall be unsigned CREDIT_W-bit. Subtraction cannot underflow because it is guarded by the >= check.

Reset
REQ-014 rst low shall asynchronously set: state IDLE, credit 0, sel 0, vend 0, vend_item 0, deny 0, DENY counter 0, synchroniser and edge registers 0. change and change_valid shall also reset to 0 when present.
REQ-015 rst asserted mid-VEND or mid-DENY shall abort immediately with no vend pulse; no event shall be generated from inputs already held high at release.

Configuration
REQ-016 Macro VM_REFUND_EN, when defined, shall add:
  input X_button, 1 bit, refund request
  output change, CREDIT_W bits, amount returned
  output change_valid, 1 bit, one-cycle pulse
  A new state REFUND (one cycle) shall be entered from CREDIT on X: change = credit, change_valid = 1, credit = 0, then IDLE.
  Coin excess above MAX_CREDIT shall be reported as change with change_valid in the same cycle instead of being discarded.
  X shall take priority over C in the same cycle.
REQ-017 Without VM_REFUND_EN, none of those ports or the REFUND state shall exist, and excess credit shall be discarded silently.

Verification
REQ-018 Reset, then switch[2] pulse -> credit = 10, state CREDIT, afford = 5'b11111.
REQ-019 Credit 10, sel 0, R pressed 3 times -> sel = 3, price = 10; C -> vend = 1 for one cycle, vend_item = 3, credit = 0, state IDLE.
REQ-020 Credit 5, sel 0 (price 7), C -> deny high for exactly 4 cycles, credit stays 5; a second C during deny is ignored.
REQ-021 sel 0, L -> sel = 4; L and R in the same cycle -> sel unchanged.
REQ-022 Credit 90, switch[3] pulse -> credit = 99; with VM_REFUND_EN, change = 11 and change_valid pulses; X afterwards -> change = 99, credit = 0.
REQ-023 rst asserted during DENY -> all outputs return to 0 asynchronously, and C held high across reset release produces no event.

Source files
------------

// File: rtl/vending_ctrl.sv
// vending_ctrl: coin vending controller with synchronised, edge-detected buttons and coins.
// Optional refund path (X_button, change, change_valid, REFUND state) enabled by defining VM_REFUND_EN.

module vending_ctrl_sync (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic din,
    output logic ev
);
    logic s1, s2, prev;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1   <= 1'b0;
            s2   <= 1'b0;
            prev <= 1'b0;
            ev   <= 1'b0;
        end else begin
            s1   <= din;
            s2   <= s1;
            prev <= s2;
            // en holds events off until prev reflects real input, so a level held across reset is not an edge
            ev   <= en & s2 & ~prev;
        end
    end
endmodule

module vending_ctrl #(
    parameter int                          N_ITEMS     = 5,
    parameter int                          CREDIT_W    = 7,
    parameter int                          MAX_CREDIT  = 99,
    parameter logic [N_ITEMS*CREDIT_W-1:0] PRICES      = {7'd8, 7'd10, 7'd6, 7'd5, 7'd7},
    parameter int                          DENY_CYCLES = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                L_button,
    input  logic                R_button,
    input  logic                C_button,
    input  logic [3:0]          switch,
`ifdef VM_REFUND_EN
    input  logic                X_button,
`endif
    output logic [2:0]          sel,
    output logic [CREDIT_W-1:0] price,
    output logic [CREDIT_W-1:0] credit,
    output logic [N_ITEMS-1:0]  afford,
    output logic                vend,
    output logic [2:0]          vend_item,
`ifdef VM_REFUND_EN
    output logic [CREDIT_W-1:0] change,
    output logic                change_valid,
`endif
    output logic                deny
);
    localparam int TW  = CREDIT_W + 2;
    localparam int DCW = (DENY_CYCLES > 2) ? $clog2(DENY_CYCLES) : 1;
    localparam logic [2:0] LAST_SEL = 3'(N_ITEMS - 1);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_CREDIT = 3'd1;
    localparam logic [2:0] S_VEND   = 3'd2;
    localparam logic [2:0] S_DENY   = 3'd3;
`ifdef VM_REFUND_EN
    localparam logic [2:0] S_REFUND = 3'd4;
    localparam int N_IN = 8;
`else
    localparam int N_IN = 7;
`endif

    logic [2:0]          state, state_nxt;
    logic [DCW-1:0]      deny_cnt, cnt_nxt;
    logic [2:0]          sel_nxt, item_nxt;
    logic [CREDIT_W-1:0] credit_nxt;
    logic [TW-1:0]       coin_sum, base, total;
    logic [2:0]          vld_pipe;
    logic [N_IN-1:0]     in_raw, in_ev;
    logic [3:0]          coin_ev;
    logic                l_ev, r_ev, c_ev, nav_ok;
`ifdef VM_REFUND_EN
    logic                x_ev, cv_nxt;
    logic [CREDIT_W-1:0] change_nxt;

    assign in_raw = {X_button, C_button, R_button, L_button, switch};
    assign x_ev   = in_ev[7];
`else
    assign in_raw = {C_button, R_button, L_button, switch};
`endif

    assign coin_ev = in_ev[3:0];
    assign l_ev    = in_ev[4];
    assign r_ev    = in_ev[5];
    assign c_ev    = in_ev[6];

    for (genvar g = 0; g < N_IN; g++) begin : g_sync
        vending_ctrl_sync u_sync (
            .clk (clk),
            .rst (rst),
            .en  (vld_pipe[2]),
            .din (in_raw[g]),
            .ev  (in_ev[g])
        );
    end

    always_comb begin
        coin_sum = '0;
        if (coin_ev[0]) coin_sum = coin_sum + TW'(1);
        if (coin_ev[1]) coin_sum = coin_sum + TW'(5);
        if (coin_ev[2]) coin_sum = coin_sum + TW'(10);
        if (coin_ev[3]) coin_sum = coin_sum + TW'(20);
    end

    always_comb begin
        price = '0;
        for (int i = 0; i < N_ITEMS; i++) begin
            if (sel == 3'(i)) price = PRICES[i*CREDIT_W +: CREDIT_W];
            afford[i] = (credit >= PRICES[i*CREDIT_W +: CREDIT_W]);
        end
    end

    assign vend   = (state == S_VEND);
    assign deny   = (state == S_DENY);
    assign nav_ok = (state == S_IDLE) || (state == S_CREDIT);

    always_comb begin
        sel_nxt = sel;
        if (nav_ok && (l_ev ^ r_ev)) begin
            if (r_ev) sel_nxt = (sel == LAST_SEL) ? 3'd0 : sel + 3'd1;
            else      sel_nxt = (sel == 3'd0) ? LAST_SEL : sel - 3'd1;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = deny_cnt;
        item_nxt  = vend_item;
        base      = TW'(credit);
`ifdef VM_REFUND_EN
        change_nxt = '0;
        cv_nxt     = 1'b0;
`endif
        case (state)
            S_IDLE: begin
                if (c_ev) begin
                    state_nxt = S_DENY;
                    cnt_nxt   = '0;
                end else if (coin_sum != '0) begin
                    state_nxt = S_CREDIT;
                end
            end
            S_CREDIT: begin
`ifdef VM_REFUND_EN
                if (x_ev) begin
                    state_nxt  = S_REFUND;
                    change_nxt = credit;
                    cv_nxt     = 1'b1;
                    base       = '0;
                end else
`endif
                if (c_ev) begin
                    // purchase is judged on the pre-coin credit; same-cycle coins land after the deduction
                    if (credit >= price) begin
                        base      = TW'(credit - price);
                        state_nxt = S_VEND;
                        item_nxt  = sel;
                    end else begin
                        state_nxt = S_DENY;
                        cnt_nxt   = '0;
                    end
                end
            end
            S_VEND: state_nxt = S_IDLE;
            S_DENY: begin
                if (deny_cnt == DCW'(DENY_CYCLES - 1)) state_nxt = S_CREDIT;
                else                                   cnt_nxt   = deny_cnt + 1'b1;
            end
`ifdef VM_REFUND_EN
            S_REFUND: state_nxt = S_IDLE;
`endif
            default: state_nxt = S_IDLE;
        endcase

        total = base + coin_sum;
        if (total > TW'(MAX_CREDIT)) begin
            credit_nxt = CREDIT_W'(MAX_CREDIT);
`ifdef VM_REFUND_EN
            change_nxt = CREDIT_W'(total - TW'(MAX_CREDIT));
            cv_nxt     = 1'b1;
`endif
        end else begin
            credit_nxt = total[CREDIT_W-1:0];
        end

        if (state == S_VEND) state_nxt = (credit_nxt != '0) ? S_CREDIT : S_IDLE;
`ifdef VM_REFUND_EN
        if (state == S_REFUND) state_nxt = (credit_nxt != '0) ? S_CREDIT : S_IDLE;
`endif
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= S_IDLE;
            credit    <= '0;
            sel       <= '0;
            vend_item <= '0;
            deny_cnt  <= '0;
            vld_pipe  <= '0;
`ifdef VM_REFUND_EN
            change       <= '0;
            change_valid <= 1'b0;
`endif
        end else begin
            state     <= state_nxt;
            credit    <= credit_nxt;
            sel       <= sel_nxt;
            vend_item <= item_nxt;
            deny_cnt  <= cnt_nxt;
            vld_pipe  <= {vld_pipe[1:0], 1'b1};
`ifdef VM_REFUND_EN
            change       <= change_nxt;
            change_valid <= cv_nxt;
`endif
        end
    end
endmodule

// File: tb/tb_vending_ctrl.sv
// tb_vending_ctrl: directed plus randomized checks of vending_ctrl against a transaction-level model.
module tb_vending_ctrl;
    localparam int DENY = 4;

    logic       clk, rst;
    logic       L_button, R_button, C_button;
    logic [3:0] switch;
    logic [2:0] sel, vend_item;
    logic [6:0] price, credit;
    logic [4:0] afford;
    logic       vend, deny;
`ifdef VM_REFUND_EN
    logic       X_button, change_valid;
    logic [6:0] change;
    int         last_change, change_seen;
`endif

    int checks, failures;
    int vend_seen, deny_seen, last_item;
    int m_credit, m_sel;
    int prices[5] = '{7, 5, 6, 10, 8};

    vending_ctrl dut (
        .clk(clk), .rst(rst), .L_button(L_button), .R_button(R_button), .C_button(C_button),
        .switch(switch),
`ifdef VM_REFUND_EN
        .X_button(X_button), .change(change), .change_valid(change_valid),
`endif
        .sel(sel), .price(price), .credit(credit), .afford(afford), .vend(vend),
        .vend_item(vend_item), .deny(deny)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (vend === 1'b1) begin
            vend_seen++;
            last_item = int'(vend_item);
        end
        if (deny === 1'b1) deny_seen++;
`ifdef VM_REFUND_EN
        if (change_valid === 1'b1) begin
            change_seen++;
            last_change = int'(change);
        end
`endif
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // m = {C, R, L, switch[3:0]}
    task automatic press(input logic [6:0] m, input int settle);
        @(negedge clk);
        switch = m[3:0]; L_button = m[4]; R_button = m[5]; C_button = m[6];
        @(negedge clk);
        switch = '0; L_button = 0; R_button = 0; C_button = 0;
        repeat (settle) @(negedge clk);
    endtask

    task automatic settle_check(input string tag, input int ev, input int ed, input int v0,
                                input int d0, input int item);
        logic [4:0] aff;
        for (int i = 0; i < 5; i++) aff[i] = (m_credit >= prices[i]);
        chk({tag, ".credit"}, 32'(credit), 32'(m_credit));
        chk({tag, ".sel"}, 32'(sel), 32'(m_sel));
        chk({tag, ".price"}, 32'(price), 32'(prices[m_sel]));
        chk({tag, ".afford"}, 32'(afford), 32'(aff));
        chk({tag, ".vends"}, 32'(vend_seen - v0), 32'(ev));
        chk({tag, ".deny_cycles"}, 32'(deny_seen - d0), 32'(ed));
        if (ev != 0) chk({tag, ".vend_item"}, 32'(last_item), 32'(item));
    endtask

    task automatic do_op(input logic [6:0] m, input string tag);
        int v0 = vend_seen;
        int d0 = deny_seen;
        int ev = 0, ed = 0, item = 0, coins;
        if (m[6]) begin
            if (m_credit >= prices[m_sel]) begin
                ev = 1; item = m_sel; m_credit -= prices[m_sel];
            end else ed = DENY;
        end
        if (m[4] ^ m[5]) m_sel = m[5] ? (m_sel + 1) % 5 : (m_sel + 4) % 5;
        coins = (m[0] ? 1 : 0) + (m[1] ? 5 : 0) + (m[2] ? 10 : 0) + (m[3] ? 20 : 0);
        m_credit = (m_credit + coins > 99) ? 99 : m_credit + coins;
        press(m, 10);
        settle_check(tag, ev, ed, v0, d0, item);
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, ".credit"}, 32'(credit), 0);
        chk({tag, ".sel"}, 32'(sel), 0);
        chk({tag, ".vend"}, 32'(vend), 0);
        chk({tag, ".vend_item"}, 32'(vend_item), 0);
        chk({tag, ".deny"}, 32'(deny), 0);
        chk({tag, ".afford"}, 32'(afford), 0);
        chk({tag, ".price"}, 32'(price), 7);
    endtask

    initial begin
        int v0, d0;
        checks = 0; failures = 0; vend_seen = 0; deny_seen = 0; last_item = 0;
        rst = 0; switch = '0; L_button = 0; R_button = 0; C_button = 0;
`ifdef VM_REFUND_EN
        X_button = 0; change_seen = 0; last_change = 0;
`endif
        m_credit = 0; m_sel = 0;
        repeat (3) @(negedge clk);
        chk_zero("reset");
        rst = 1;
        repeat (6) @(negedge clk);

        do_op(7'b0000100, "coin10");
        chk("coin10.afford_all", 32'(afford), 32'h1f);
        do_op(7'b0100000, "r1");
        do_op(7'b0100000, "r2");
        do_op(7'b0100000, "r3");
        chk("r3.price10", 32'(price), 10);
        do_op(7'b1000000, "buy3");
        do_op(7'b0000010, "coin5");
        do_op(7'b0010000, "l1");
        do_op(7'b0010000, "l2");
        do_op(7'b0010000, "l3");

        // second C arrives while deny is still running and must not extend it
        v0 = vend_seen; d0 = deny_seen;
        press(7'b1000000, 0);
        press(7'b1000000, 12);
        settle_check("deny_twice", 0, DENY, v0, d0, 0);

        do_op(7'b1000010, "c_plus_coin_deny");
        do_op(7'b1000001, "c_plus_coin_vend");
        do_op(7'b0010000, "l_wrap");
        do_op(7'b0110000, "l_and_r");
        repeat (4) do_op(7'b0001000, "coin20");
        do_op(7'b0000011, "coin1_5");
        chk("credit90", 32'(credit), 90);
`ifdef VM_REFUND_EN
        v0 = change_seen;
`endif
        do_op(7'b0001000, "saturate");
`ifdef VM_REFUND_EN
        chk("excess.count", 32'(change_seen - v0), 1);
        chk("excess.change", 32'(last_change), 11);
        v0 = change_seen;
        @(negedge clk); X_button = 1;
        @(negedge clk); X_button = 0;
        repeat (10) @(negedge clk);
        m_credit = 0;
        chk("refund.count", 32'(change_seen - v0), 1);
        chk("refund.change", 32'(last_change), 99);
        chk("refund.credit", 32'(credit), 0);
`endif

        // async reset mid-deny, with C held across release
        rst = 0; #2; rst = 1; m_credit = 0; m_sel = 0;
        repeat (6) @(negedge clk);
        press(7'b1000000, 3);
        chk("pre_reset.deny", 32'(deny), 1);
        #2; C_button = 1; rst = 0; #1;
        chk_zero("async_reset");
        v0 = vend_seen; d0 = deny_seen;
        repeat (2) @(negedge clk);
        rst = 1;
        repeat (8) @(negedge clk);
        C_button = 0;
        repeat (8) @(negedge clk);
        settle_check("held_c_release", 0, 0, v0, d0, 0);

        for (int n = 0; n < 40; n++) do_op(7'($urandom), $sformatf("rand%0d", n));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
